// File: rtl/axis_ctrl_pkg.sv
// Shared definitions for the AXIS control wrapper: command constants,
// FSM state encodings for the write and read paths, and BRAM index width.
package axis_ctrl_pkg;

    localparam logic [15:0] MAGIC_WORD  = 16'hC0DE;
    localparam logic [15:0] INSTR_WRITE = 16'h0001;
    localparam logic [15:0] INSTR_READ  = 16'h0002;

    localparam int unsigned BRAM_IDX_W = 5;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_CHECK,
        WR_RECV,
        WR_DONE
    } write_state_t;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_CHECK,
        RD_STREAM,
        RD_DRAIN,
        RD_DONE
    } read_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer with registered valid/data. The producer is
// credit-managed through level and must never push while two entries are held.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             pop;

    assign m_valid = (level != 2'd0);
    assign m_data  = mem[rd_ptr];
    assign pop     = m_valid && m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (s_valid) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level + 2'(s_valid) - 2'(pop);
        end
    end

endmodule

// File: rtl/axis_bram_read_streamer.sv
// Streams a BRAM-major sweep of the flattened BRAM read port onto AXIS.
// Optional READ_HEADER_EN prefixes each stream with MAGIC_WORD and the beat count.
module axis_bram_read_streamer
    import axis_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BRAM_COUNT = 8,
    parameter int unsigned BRAM_DEPTH = 512,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             cmd_start,
    input  logic [BRAM_IDX_W-1:0]            cmd_bram_start,
    input  logic [BRAM_IDX_W-1:0]            cmd_bram_end,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr_start,
    input  logic [15:0]                      cmd_count,
    output logic [ADDR_WIDTH-1:0]            bram_rd_addr,
    input  logic [BRAM_COUNT*DATA_WIDTH-1:0] bram_rd_data_flat,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic                             read_done,
    output logic                             busy,
    output logic                             cmd_error
);

    read_state_t state, state_nxt;

    logic [BRAM_IDX_W-1:0] bram_start_q, bram_end_q, bram_q, pipe_bram;
    logic [ADDR_WIDTH-1:0] addr_start_q;
    logic [15:0]           count_q, word_cnt;
    logic                  cmd_ok, word_end, last_word;
    logic                  issue, data_issue, room, pop;
    logic                  pipe_valid, pipe_last;
    logic [DATA_WIDTH-1:0] rd_word, beat_data;
    logic [1:0]            skid_level;

    assign cmd_ok    = (bram_end_q > bram_start_q) && (32'(bram_end_q) <= BRAM_COUNT) &&
                       (count_q != '0);
    assign word_end  = (word_cnt == count_q - 16'd1);
    assign last_word = word_end && (bram_q == bram_end_q - BRAM_IDX_W'(1));
    assign pop       = m_axis_tvalid && m_axis_tready;
    // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle under full flow.
    assign room      = ({1'b0, skid_level} + {2'b00, pipe_valid}) < (3'd2 + {2'b00, pop});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= RD_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RD_IDLE:   if (cmd_start) state_nxt = RD_CHECK;
            RD_CHECK:  state_nxt = cmd_ok ? RD_STREAM : RD_IDLE;
            RD_STREAM: if (data_issue && last_word) state_nxt = RD_DRAIN;
            RD_DRAIN:  if (pop && m_axis_tlast) state_nxt = RD_DONE;
            RD_DONE:   state_nxt = RD_IDLE;
            default:   state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        cmd_error = 1'b0;
        read_done = 1'b0;
        issue     = 1'b0;
        unique case (state)
            RD_CHECK: begin
                busy      = cmd_ok;
                cmd_error = !cmd_ok;
            end
            RD_STREAM: begin
                busy  = 1'b1;
                issue = room;
            end
            RD_DRAIN: busy      = 1'b1;
            RD_DONE:  read_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bram_start_q <= '0;
            bram_end_q   <= '0;
            addr_start_q <= '0;
            count_q      <= '0;
            bram_q       <= '0;
            word_cnt     <= '0;
            bram_rd_addr <= '0;
            pipe_valid   <= 1'b0;
            pipe_bram    <= '0;
            pipe_last    <= 1'b0;
        end else begin
            if (state == RD_IDLE && cmd_start) begin
                bram_start_q <= cmd_bram_start;
                bram_end_q   <= cmd_bram_end;
                addr_start_q <= cmd_addr_start;
                count_q      <= cmd_count;
            end
            if (state == RD_CHECK) begin
                bram_q       <= bram_start_q;
                word_cnt     <= '0;
                bram_rd_addr <= addr_start_q;
            end else if (data_issue) begin
                if (word_end) begin
                    word_cnt     <= '0;
                    bram_q       <= bram_q + BRAM_IDX_W'(1);
                    bram_rd_addr <= addr_start_q;
                end else begin
                    word_cnt     <= word_cnt + 16'd1;
                    bram_rd_addr <= (bram_rd_addr == ADDR_WIDTH'(BRAM_DEPTH - 1)) ?
                                    '0 : bram_rd_addr + ADDR_WIDTH'(1);
                end
            end
            pipe_valid <= issue;
            pipe_bram  <= bram_q;
            pipe_last  <= data_issue && last_word;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned b = 0; b < BRAM_COUNT; b++) begin
            if (pipe_bram == BRAM_IDX_W'(b)) rd_word = bram_rd_data_flat[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef READ_HEADER_EN
    logic [1:0]            hdr_left;
    logic [15:0]           total_q;
    logic                  pipe_hdr;
    logic [DATA_WIDTH-1:0] pipe_hdr_word;

    // Header beats ride the read pipeline as pseudo-reads, so they take buffer credit normally.
    assign data_issue = issue && (hdr_left == 2'd0);
    assign beat_data  = pipe_hdr ? pipe_hdr_word : rd_word;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hdr_left      <= 2'd0;
            total_q       <= '0;
            pipe_hdr      <= 1'b0;
            pipe_hdr_word <= '0;
        end else begin
            if (state == RD_CHECK) begin
                hdr_left <= 2'd2;
                total_q  <= 16'(bram_end_q - bram_start_q) * count_q;
            end else if (issue && hdr_left != 2'd0) begin
                hdr_left <= hdr_left - 2'd1;
            end
            pipe_hdr      <= issue && (hdr_left != 2'd0);
            pipe_hdr_word <= (hdr_left == 2'd2) ? DATA_WIDTH'(MAGIC_WORD) : DATA_WIDTH'(total_q);
        end
    end
`else
    assign data_issue = issue;
    assign beat_data  = rd_word;
`endif

    axis_skid_buffer #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (pipe_valid),
        .s_data  ({pipe_last, beat_data}),
        .m_valid (m_axis_tvalid),
        .m_data  ({m_axis_tlast, m_axis_tdata}),
        .m_ready (m_axis_tready),
        .level   (skid_level)
    );

endmodule

// File: tb/tb_axis_bram_read_streamer.sv
// Directed and randomized checks of axis_bram_read_streamer against a queue-based
// model of the expected stream; honours READ_HEADER_EN when defined.
module tb_axis_bram_read_streamer;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         cmd_start;
    logic [4:0]   cmd_bram_start, cmd_bram_end;
    logic [8:0]   cmd_addr_start;
    logic [15:0]  cmd_count;
    logic [8:0]   bram_rd_addr;
    logic [127:0] bram_rd_data_flat;
    logic [15:0]  m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic         read_done, busy, cmd_error;

    logic [15:0] mem [8][512];
    logic [15:0] rd_q [8];

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 aclk = ~aclk;

    axis_bram_read_streamer #(
        .DATA_WIDTH(16),
        .BRAM_COUNT(8),
        .BRAM_DEPTH(512),
        .ADDR_WIDTH(9)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .cmd_start         (cmd_start),
        .cmd_bram_start    (cmd_bram_start),
        .cmd_bram_end      (cmd_bram_end),
        .cmd_addr_start    (cmd_addr_start),
        .cmd_count         (cmd_count),
        .bram_rd_addr      (bram_rd_addr),
        .bram_rd_data_flat (bram_rd_data_flat),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .read_done         (read_done),
        .busy              (busy),
        .cmd_error         (cmd_error)
    );

    // Synchronous-read BRAM model: data appears one cycle after the address.
    always @(posedge aclk) begin
        for (int b = 0; b < 8; b++) rd_q[b] <= mem[b][bram_rd_addr];
    end

    always_comb begin
        for (int b = 0; b < 8; b++) bram_rd_data_flat[b*16 +: 16] = rd_q[b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input int unsigned bs, input int unsigned be, input int unsigned as,
                           input int unsigned cnt, input bit rnd, input int unsigned abort_at);
        logic [15:0] exp_q [$];
        bit          ok, last_acc, done, stall, saw;
        int unsigned beats, cyc, first_cyc, budget, size;
        logic [31:0] prev;

        ok = (be > bs) && (be <= 8) && (cnt != 0);
        if (ok) begin
`ifdef READ_HEADER_EN
            exp_q.push_back(16'hC0DE);
            exp_q.push_back(16'((be - bs) * cnt));
`endif
            for (int unsigned b = bs; b < be; b++)
                for (int unsigned i = 0; i < cnt; i++)
                    exp_q.push_back(mem[b][(as + i) % 512]);
        end
        size = exp_q.size();

        cmd_bram_start = 5'(bs);
        cmd_bram_end   = 5'(be);
        cmd_addr_start = 9'(as);
        cmd_count      = 16'(cnt);
        cmd_start      = 1'b1;
        @(negedge aclk);
        cmd_start = 1'b0;
        chk("accept_flags", {30'd0, busy, cmd_error}, ok ? 32'd2 : 32'd1);

        if (!ok) begin
            saw = 1'b0;
            repeat (6) begin
                @(negedge aclk);
                saw |= m_axis_tvalid | read_done | cmd_error | busy;
            end
            chk("reject_quiet", {31'd0, saw}, 32'd0);
            @(negedge aclk);
            return;
        end

        beats = 0; cyc = 1; first_cyc = 0;
        last_acc = 1'b0; done = 1'b0; stall = 1'b0; prev = '0;
        budget = size * 8 + 40;
        while (!done && cyc < budget) begin
            if (last_acc) begin
                chk("done_pulse", {29'd0, read_done, busy, m_axis_tvalid}, 32'd4);
                done = 1'b1;
            end else begin
                if (abort_at != 0 && beats == abort_at) return;
                if (read_done) chk("early_done", {31'd0, read_done}, 32'd0);
                if (stall) chk("stall_hold", {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata}, prev);
                if (m_axis_tvalid && first_cyc == 0) begin
                    first_cyc = cyc;
                    chk("first_latency", cyc, 32'd4);
                end
                m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_axis_tvalid && m_axis_tready) begin
                    chk("beat_data", {16'd0, m_axis_tdata}, {16'd0, exp_q[beats]});
                    chk("beat_last", {31'd0, m_axis_tlast}, {31'd0, beats == size - 1});
                    if (!rnd && beats == size - 1) chk("throughput", cyc - first_cyc, size - 1);
                    beats++;
                    if (beats == size) last_acc = 1'b1;
                end
                stall = m_axis_tvalid && !m_axis_tready;
                prev  = {14'd0, m_axis_tvalid, m_axis_tlast, m_axis_tdata};
            end
            @(negedge aclk);
            cyc++;
        end
        chk("beat_total", beats, size);
        chk("finished", {31'd0, done}, 32'd1);
        @(negedge aclk);
    endtask

    initial begin
        int unsigned bs, be;

        aresetn        = 1'b0;
        cmd_start      = 1'b0;
        cmd_bram_start = '0;
        cmd_bram_end   = '0;
        cmd_addr_start = '0;
        cmd_count      = '0;
        m_axis_tready  = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 512; a++)
                mem[b][a] = 16'hB000 + 16'(b << 8) + 16'(a);

        #1;
        chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, read_done, busy, cmd_error,
                              bram_rd_addr}, 32'd0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        run_cmd(2, 6, 0, 42, 1'b0, 0);
        run_cmd(2, 6, 0, 42, 1'b1, 0);
        run_cmd(0, 1, 510, 4, 1'b0, 0);

        run_cmd(3, 3, 0, 5, 1'b0, 0);
        run_cmd(0, 9, 0, 5, 1'b0, 0);
        run_cmd(0, 4, 0, 0, 1'b0, 0);

        run_cmd(2, 6, 0, 42, 1'b0, 20);
        aresetn = 1'b0;
        #1;
        chk("reset_mid_stream", {28'd0, m_axis_tvalid, m_axis_tlast, read_done, busy}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        run_cmd(0, 2, 7, 5, 1'b0, 0);

        run_cmd(1, 2, 0, 3, 1'b1, 0);

        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 512; a++)
                mem[b][a] = 16'($urandom);
        for (int t = 0; t < 6; t++) begin
            bs = $urandom_range(0, 7);
            be = $urandom_range(bs + 1, 8);
            run_cmd(bs, be, $urandom_range(0, 511), $urandom_range(1, 40), 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
